// File: rtl/vc_bus_pkg.sv
// Shared definitions for the CPU-side memory bus: arbiter state encodings,
// read-request half-select constants and the address-field width helper.
// Used by the memory arbiter and the bus sequencer.
package vc_bus_pkg;

  // Arbiter states
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2,
    ARB_GAP  = 2'd3
  } arb_state_t;

  // Read-request half selects: bit0 = low half, bit1 = high half
  localparam logic [1:0] RREQ_LO   = 2'b01;
  localparam logic [1:0] RREQ_HI   = 2'b10;
  localparam logic [1:0] RREQ_BOTH = RREQ_LO | RREQ_HI;

  // Statistics counter bank geometry
  localparam int STAT_N = 4;
  localparam int STAT_W = 16;

  // Width of an address field spanning [rv-1:rv/16]
  function automatic int addr_width(input int rv);
    return rv - rv / 16;
  endfunction

endpackage

// File: rtl/vc_arb_stats.sv
// Arbiter statistics bank: four saturating 16-bit event counters with a
// registered read port. Only instantiated when VC_ARB_STATS_EN is defined.
// Counter map: 0 = port-0 grants, 1 = port-1 grants,
//              2 = port-0 wait cycles, 3 = port-1 wait cycles.
module vc_arb_stats
  import vc_bus_pkg::*;
(
  input  logic              clk,
  input  logic              r_reset,
  input  logic [STAT_N-1:0] i_inc,
  input  logic [1:0]        i_sel,
  output logic [STAT_W-1:0] o_data
);

  logic [STAT_N-1:0][STAT_W-1:0] w_cnt;
  logic [STAT_W-1:0]             r_data;

  generate
    for (genvar gi = 0; gi < STAT_N; gi++) begin : g_cnt
      logic [STAT_W-1:0] r_cnt;

      // Saturating event counter; holds at all-ones instead of wrapping
      always_ff @(posedge clk) begin
        if (r_reset) begin
          r_cnt <= '0;
        end else if (i_inc[gi] && (r_cnt != {STAT_W{1'b1}})) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_cnt[gi] = r_cnt;
    end
  endgenerate

  // Registered read of the selected counter (one cycle of latency)
  always_ff @(posedge clk) begin
    if (r_reset) begin
      r_data <= '0;
    end else begin
      r_data <= w_cnt[i_sel];
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/vc_mem_arbiter.sv
// Two-port arbiter in front of the bus sequencer's single CPU-side memory port.
// Port 0 is instruction fetch (read only), port 1 is data (read/write).
// Port 1 has priority; a starvation counter forces a port-0 grant after
// STARVE_LIMIT consecutive port-1 grants made while port 0 was waiting.
// Every transaction is followed by a one-cycle GAP so that a request still
// held during its done cycle cannot be granted a second time.
// Optional feature: define VC_ARB_STATS_EN to add the stat_sel/stat_data
// statistics port and the vc_arb_stats counter bank.
module vc_mem_arbiter
  import vc_bus_pkg::*;
#(
  parameter int RV           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 r_reset,
  // port 0: instruction fetch
  input  logic [RV-1:RV/16]    p0_raddr,
  input  logic [1:0]           p0_rreq,
  output logic [RV-1:0]        p0_rdata,
  output logic                 p0_rdone,
  // port 1: data
  input  logic [RV-1:RV/16]    p1_raddr,
  input  logic [1:0]           p1_rreq,
  output logic [RV-1:0]        p1_rdata,
  output logic                 p1_rdone,
  input  logic [RV-1:RV/16]    p1_waddr,
  input  logic [RV/8-1:0]      p1_wmask,
  input  logic [RV-1:0]        p1_wdata,
  output logic                 p1_wdone,
  // sequencer side
  output logic [RV-1:RV/16]    m_raddr,
  output logic [1:0]           m_rreq,
  input  logic [RV-1:0]        m_rdata,
  input  logic                 m_rdone,
  output logic [RV-1:RV/16]    m_waddr,
  output logic [RV/8-1:0]      m_wmask,
  output logic [RV-1:0]        m_wdata,
  input  logic                 m_wdone,
`ifdef VC_ARB_STATS_EN
  input  logic [1:0]           stat_sel,
  output logic [STAT_W-1:0]    stat_data,
`endif
  output logic                 busy
);

  localparam int AW = addr_width(RV);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t   r_state;
  logic [1:0]   r_grant;        // one-hot: bit0 = port 0, bit1 = port 1
  logic [3:0]   r_starve_cnt;

  logic         w_p0_pend;
  logic         w_p1_pend;
  logic         w_starved;
  logic         w_take0;
  logic         w_take1;
  logic         w_done;

  logic [AW-1:0]   w_raddr;
  logic [1:0]      w_rreq;
  logic [AW-1:0]   w_waddr;
  logic [RV/8-1:0] w_wmask;
  logic [RV-1:0]   w_wdata;

  assign w_p0_pend = |(p0_rreq & RREQ_BOTH);
  assign w_p1_pend = (|(p1_rreq & RREQ_BOTH)) | (|p1_wmask);
  assign w_starved = w_p0_pend && (r_starve_cnt == LIMIT);

  // Grant decisions are only taken in IDLE
  assign w_take1 = (r_state == ARB_IDLE) && w_p1_pend && !w_starved;
  assign w_take0 = (r_state == ARB_IDLE) && w_p0_pend && !w_take1;
  assign w_done  = m_rdone | m_wdone;

  // Arbitration FSM, grant register and starvation counter
  always_ff @(posedge clk) begin
    if (r_reset) begin
      r_state      <= ARB_IDLE;
      r_grant      <= 2'b00;
      r_starve_cnt <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_take1) begin
            r_state <= ARB_GNT1;
            r_grant <= 2'b10;
            if (w_p0_pend && (r_starve_cnt != 4'hF)) begin
              r_starve_cnt <= r_starve_cnt + 4'd1;
            end
          end else if (w_take0) begin
            r_state <= ARB_GNT0;
            r_grant <= 2'b01;
          end
          // A port-0 grant or an idle port 0 restarts the starvation count
          if (w_take0 || !w_p0_pend) begin
            r_starve_cnt <= '0;
          end
        end
        ARB_GNT0, ARB_GNT1: begin
          // Any completion ends the grant, including a write that was
          // forwarded together with a read; the read re-arbitrates later.
          if (w_done) begin
            r_state <= ARB_GAP;
            r_grant <= 2'b00;
          end
        end
        ARB_GAP: begin
          r_state <= ARB_IDLE;
        end
        default: begin
          r_state <= ARB_IDLE;
          r_grant <= 2'b00;
        end
      endcase
    end
  end

  // Request mux towards the sequencer; everything zero when nothing is granted
  always_comb begin
    w_raddr = '0;
    w_rreq  = 2'b00;
    w_waddr = '0;
    w_wmask = '0;
    w_wdata = '0;
    if (r_grant[0]) begin
      // fetch port is read only: write mask stays forced to zero
      w_raddr = p0_raddr;
      w_rreq  = p0_rreq;
    end else if (r_grant[1]) begin
      w_raddr = p1_raddr;
      w_rreq  = p1_rreq;
      w_waddr = p1_waddr;
      w_wmask = p1_wmask;
      w_wdata = p1_wdata;
    end
  end

  assign m_raddr = w_raddr;
  assign m_rreq  = w_rreq;
  assign m_waddr = w_waddr;
  assign m_wmask = w_wmask;
  assign m_wdata = w_wdata;

  // Completions are steered to the granted port only; a stray done pulse
  // outside a grant is dropped because the grant register is zero then.
  assign p0_rdone = r_grant[0] & m_rdone;
  assign p1_rdone = r_grant[1] & m_rdone;
  assign p1_wdone = r_grant[1] & m_wdone;

  // Read data is shared; consumers qualify it with their own done
  assign p0_rdata = m_rdata;
  assign p1_rdata = m_rdata;

  assign busy = |r_grant;

`ifdef VC_ARB_STATS_EN
  logic [STAT_N-1:0] w_stat_inc;

  assign w_stat_inc[0] = w_take0;
  assign w_stat_inc[1] = w_take1;
  assign w_stat_inc[2] = w_p0_pend & ~r_grant[0];
  assign w_stat_inc[3] = w_p1_pend & ~r_grant[1];

  vc_arb_stats u_stats (
    .clk     (clk),
    .r_reset (r_reset),
    .i_inc   (w_stat_inc),
    .i_sel   (stat_sel),
    .o_data  (stat_data)
  );
`endif

endmodule
